// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam int         DATA_W_DEF = 32;
  localparam int         ADDR_W     = 32;

  // Misaligned, or any address bit above the word index is set.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int idx_w);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (idx_w + 2);
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM; read data register only updates on a read access.
module dmem_ram
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= din;
      end else begin
        dout_q <= mem_q[idx];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, one-cycle ack/err.
//
// state  | meaning
// S_IDLE | waiting for req; request fields latched on acceptance
// S_WAIT | counting wait states down to zero
// S_RESP | ack or err pulse cycle; RAM was accessed on the edge entering this state
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;

  logic              enter_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_bad;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    rd_valid_d = rd_valid_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    cur_we     = we_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;

    case (state_q)
      S_IDLE: begin
        // With no wait states the response is entered on the accepting edge,
        // so the live inputs stand in for the not-yet-latched copy.
        cur_we    = we;
        cur_addr  = addr;
        cur_wdata = wdata;
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    cur_bad = addr_bad(cur_addr, IDX_W);

    if (enter_resp) begin
      state_d = S_RESP;
      ack_d   = !cur_bad;
      err_d   = cur_bad;
      if (cur_bad) begin
        rd_valid_d = 1'b0;
      end else if (!cur_we) begin
        rd_valid_d = 1'b1;
      end
    end

    // Gated by rst_n so a reset on the commit edge drops the pending store.
    ram_en = enter_resp && !cur_bad && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  dmem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (cur_we),
    .idx (cur_addr[IDX_W+1:2]),
    .din (cur_wdata),
    .dout(ram_dout)
  );

  // RAM output is not reset; rd_valid_q forces zero after reset and after err.
  assign rdata = rd_valid_q ? ram_dout : '0;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: instance 0 has two wait states, instance 1 has none.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_r   [2];
  logic        we_r    [2];
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];
  logic [31:0] rdata_w [2];
  logic        ack_w   [2];
  logic        err_w   [2];
  logic        busy_w  [2];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [2][256];

  data_mem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_r[0]), .we(we_r[0]), .addr(addr_r[0]),
    .wdata(wdata_r[0]), .rdata(rdata_w[0]), .ack(ack_w[0]), .err(err_w[0]), .busy(busy_w[0])
  );

  data_mem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_r[1]), .we(we_r[1]), .addr(addr_r[1]),
    .wdata(wdata_r[1]), .rdata(rdata_w[1]), .ack(ack_w[1]), .err(err_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on instance u; expectations come from the bench model.
  task automatic txn(input int u, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit scramble);
    exp_t e;
    exp_t r;
    logic bad;
    int   lat;
    int   cyc;
    bit   got;
    bad      = (a[1:0] != 2'b00) || (a >= 32'h400);
    e.is_err = bad;
    e.rdata  = bad ? 32'h0 : mdl[u][a[9:2]];
    if (!bad && w) mdl[u][a[9:2]] = d;
    sbq.push_back(e);
    lat = (u == 0) ? 3 : 1;

    @(negedge clk);
    req_r[u] = 1'b1; we_r[u] = w; addr_r[u] = a; wdata_r[u] = d;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1 && u == 0) begin
        chk("busy_in_wait", 32'(busy_w[u]), 32'd1);
        if (scramble) begin
          addr_r[u]  = a ^ 32'h4;
          wdata_r[u] = ~d;
        end
      end
      if (ack_w[u] || err_w[u]) begin
        got = 1'b1;
        cyc = i;
        break;
      end
    end
    chk("response_seen", 32'(got), 32'd1);
    if (got) begin
      r = sbq.pop_front();
      chk("latency", 32'(cyc), 32'(lat));
      chk("ack", 32'(ack_w[u]), 32'(!r.is_err));
      chk("err", 32'(err_w[u]), 32'(r.is_err));
      chk("busy_in_resp", 32'(busy_w[u]), 32'd1);
      if (!w || r.is_err) chk("rdata", rdata_w[u], r.rdata);
    end
    req_r[u] = 1'b0; we_r[u] = 1'b0; addr_r[u] = $urandom; wdata_r[u] = $urandom;
    @(posedge clk);
    @(negedge clk);
    chk("single_pulse", 32'(ack_w[u] | err_w[u]), 32'd0);
    chk("busy_cleared", 32'(busy_w[u]), 32'd0);
  endtask

  initial begin
    int seen;
    int n_ack;
    int first_ack;
    int second_ack;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req_r[u] = 1'b0; we_r[u] = 1'b0; addr_r[u] = '0; wdata_r[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_rdata", rdata_w[u], 32'h0);
      chk("reset_ack", 32'(ack_w[u]), 32'd0);
      chk("reset_err", 32'(err_w[u]), 32'd0);
      chk("reset_busy", 32'(busy_w[u]), 32'd0);
    end
    rst_n = 1'b1;

    txn(0, 1'b1, 32'h10, 32'h12345678, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h0, 32'hA5A50000, 1'b0);
    txn(0, 1'b1, 32'h20, 32'h11111111, 1'b0);

    // Store aborted by reset in its second wait cycle.
    @(negedge clk);
    req_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 32'h20; wdata_r[0] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ack", 32'(ack_w[0]), 32'd0);
    chk("abort_err", 32'(err_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    rst_n = 1'b1;
    req_r[0] = 1'b0; we_r[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_w[0] || err_w[0]) seen++;
    end
    chk("abort_no_late_resp", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0);

    txn(0, 1'b0, 32'h13, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0);
    txn(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b1);
    txn(0, 1'b0, 32'h3FC, 32'h0, 1'b1);

    txn(1, 1'b1, 32'h4, 32'h0BADF00D, 1'b0);
    txn(1, 1'b0, 32'h4, 32'h0, 1'b0);

    // req held high with no wait states: acks at cycles 1, 3, 5, 7.
    @(negedge clk);
    req_r[1] = 1'b1; we_r[1] = 1'b1; addr_r[1] = 32'h8; wdata_r[1] = 32'h000055AA;
    n_ack = 0; first_ack = 0; second_ack = 0; seen = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (err_w[1]) seen++;
      if (ack_w[1]) begin
        if (n_ack == 0) first_ack = i;
        else if (n_ack == 1) second_ack = i;
        n_ack++;
      end
    end
    req_r[1] = 1'b0; we_r[1] = 1'b0;
    mdl[1][2] = 32'h000055AA;
    chk("held_first_ack", 32'(first_ack), 32'd1);
    chk("held_second_ack", 32'(second_ack), 32'd3);
    chk("held_ack_count", 32'(n_ack), 32'd4);
    chk("held_no_err", 32'(seen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    txn(1, 1'b0, 32'h8, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h6, 32'h0, 1'b0);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
